// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field widths and flag layout for the processing-element datapath.
package fp32_pkg;

   localparam int FP32_BIAS    = 127;
   localparam int FP32_EXP_MAX = 255;
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;
   localparam int FP32_PROD_W = 48;

   // out_flags = {overflow, underflow, inexact}
   localparam int FLAG_W   = 3;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_NX  = 0;

   typedef logic [FLAG_W-1:0] fp32_flags_t;

   function automatic logic [31:0] fp32_inf(input logic sign);
      return {sign, {FP32_EXP_W{1'b1}}, {FP32_FRAC_W{1'b0}}};
   endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and special-case packing of a normalised significand.
module fp32_round_pack
   import fp32_pkg::*;
#(
   parameter int EXP_W = 10
) (
   input  logic                   sign,
   input  logic signed [EXP_W:0]  e1,
   input  logic [24:0]            sig,
   input  logic                   sticky,
   input  logic                   zero,
   input  logic                   is_nan,
   input  logic                   is_inf,
   output logic [31:0]            data,
   output fp32_flags_t            flags
);

   localparam logic signed [EXP_W+1:0] E_MAX   = (EXP_W+2)'(FP32_EXP_MAX);
   localparam logic signed [EXP_W:0]   E1_ZERO = '0;

   function automatic logic [FP32_FRAC_W:0] round_rne(input logic [FP32_FRAC_W-1:0] f,
                                                      input logic g, input logic s);
      logic inc;
      inc = g & (s | f[0]);
      return {1'b0, f} + {{FP32_FRAC_W{1'b0}}, inc};
   endfunction

   logic [FP32_FRAC_W-1:0] frac;
   logic                   g;
   logic                   s;
   logic [FP32_FRAC_W:0]   rnd;
   logic signed [EXP_W+1:0] e;

   always_comb begin
      frac = sig[24:2];
      g    = sig[1];
      s    = sig[0] | sticky;
      rnd  = round_rne(frac, g, s);
      e    = {e1[EXP_W], e1} + {{(EXP_W+1){1'b0}}, rnd[FP32_FRAC_W]};
   end

   // Underflow is judged on the pre-round exponent so a carry cannot lift e1=0 into range.
   always_comb begin
      data  = {sign, e[7:0], rnd[FP32_FRAC_W-1:0]};
      flags = '0;
      flags[FLAG_NX] = g | s;
      if (is_nan) begin
         data  = FP32_QNAN;
         flags = '0;
      end else if (is_inf) begin
         data  = fp32_inf(sign);
         flags = '0;
      end else if (zero) begin
         data  = {sign, 31'b0};
         flags = '0;
      end else if (e >= E_MAX) begin
         data  = fp32_inf(sign);
         flags = '0;
         flags[FLAG_OVF] = 1'b1;
         flags[FLAG_NX]  = 1'b1;
      end else if (e1 <= E1_ZERO) begin
         data  = {sign, 31'b0};
         flags = '0;
         flags[FLAG_UNF] = 1'b1;
         flags[FLAG_NX]  = 1'b1;
      end
   end

endmodule

// File: rtl/fp32_norm_round.sv
// Post-multiply normalise / round / pack stage: 2-deep pipeline with valid/ready on both sides.
module fp32_norm_round
   import fp32_pkg::*;
#(
   parameter int EXP_W = 10,
   parameter int LZ_W  = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [EXP_W-1:0] in_exp,
   input  logic [47:0]             in_mant,
   input  logic [LZ_W-1:0]         in_lz,
   input  logic                    in_is_nan,
   input  logic                    in_is_inf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic [2:0]              out_flags
);

   logic adv1;
   logic adv2;
   logic vld_p1;
   logic vld_p2;

   logic                   zero_c;
   logic [46:0]            sh_c;
   logic signed [EXP_W:0]  e1_c;

   logic                   sign_p1;
   logic                   nan_p1;
   logic                   inf_p1;
   logic                   zero_p1;
   logic [24:0]            sig_p1;
   logic                   sticky_p1;
   logic signed [EXP_W:0]  e1_p1;

   logic [31:0]            rp_data;
   fp32_flags_t            rp_flags;
   logic [31:0]            data_p2;
   fp32_flags_t            flags_p2;

   assign adv2      = ~vld_p2 | out_ready;
   assign adv1      = ~vld_p1 | adv2;
   assign in_ready  = adv1;
   assign out_valid = vld_p2;
   assign out_data  = data_p2;
   assign out_flags = flags_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (adv1) vld_p1 <= in_valid;
         if (adv2) vld_p2 <= vld_p1;
      end
   end

   // Stage 1: normalise so the leading one sits at bit 47 (dropped, implied by ~zero).
   always_comb begin
      zero_c = (in_mant == '0) || (int'(in_lz) >= FP32_PROD_W);
      sh_c   = 47'(in_mant << in_lz);
      e1_c   = {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(1) - (EXP_W+1)'(in_lz);
   end

   always_ff @(posedge clk) begin
      if (in_valid && adv1) begin
         sign_p1   <= in_sign;
         nan_p1    <= in_is_nan;
         inf_p1    <= in_is_inf;
         zero_p1   <= zero_c;
         sig_p1    <= sh_c[46:22];
         sticky_p1 <= |sh_c[21:0];
         e1_p1     <= e1_c;
      end
   end

   // Stage 2: round and pack into the output register.
   fp32_round_pack #(
      .EXP_W (EXP_W)
   ) u_round_pack (
      .sign   (sign_p1),
      .e1     (e1_p1),
      .sig    (sig_p1),
      .sticky (sticky_p1),
      .zero   (zero_p1),
      .is_nan (nan_p1),
      .is_inf (inf_p1),
      .data   (rp_data),
      .flags  (rp_flags)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_p2  <= '0;
         flags_p2 <= '0;
      end else if (vld_p1 && adv2) begin
         data_p2  <= rp_data;
         flags_p2 <= rp_flags;
      end
   end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Bench for fp32_norm_round: directed vector table, handshake sequences and a randomized scoreboard.
module tb_fp32_norm_round;

   localparam int EXP_W = 10;
   localparam int LZ_W  = 6;

   typedef struct {
      logic              sign;
      logic signed [9:0] exp;
      logic [47:0]       mant;
      logic [5:0]        lz;
      logic              nan;
      logic              inf;
   } beat_t;

   typedef struct {
      string       name;
      beat_t       b;
      logic [31:0] data;
      logic [2:0]  flags;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic                    in_sign = 1'b0;
   logic signed [EXP_W-1:0] in_exp = '0;
   logic [47:0]             in_mant = '0;
   logic [LZ_W-1:0]         in_lz = '0;
   logic                    in_is_nan = 1'b0;
   logic                    in_is_inf = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [31:0]             out_data;
   logic [2:0]              out_flags;

   int checks = 0;
   int failures = 0;

   logic [34:0] exp_q[$];
   bit          sb_en = 1'b0;
   bit          stall_prev = 1'b0;
   logic [31:0] held_d;
   logic [2:0]  held_f;

   always #5 clk = ~clk;

   fp32_norm_round #(
      .EXP_W (EXP_W),
      .LZ_W  (LZ_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_lz     (in_lz),
      .in_is_nan (in_is_nan),
      .in_is_inf (in_is_inf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: value = mant * 2^(exp-127-46), rounded to 24 significant bits by integer arithmetic.
   function automatic logic [34:0] model(input beat_t b);
      int p, e, er, sh;
      longint unsigned m, q, rem, half;
      logic inx;
      if (b.nan) return {3'b000, 32'h7FC0_0000};
      if (b.inf) return {3'b000, b.sign, 8'hFF, 23'h0};
      if (b.mant == 0 || b.lz >= 6'd48) return {3'b000, b.sign, 31'h0};
      m = 64'(b.mant);
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      e = int'(b.exp) + p - 46;
      if (p >= 23) begin
         sh   = p - 23;
         q    = m >> sh;
         rem  = m - (q << sh);
         half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
         inx  = (rem != 0);
         if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
      end else begin
         q   = m << (23 - p);
         inx = 1'b0;
      end
      er = e;
      if (q == (64'd1 << 24)) begin
         q  = q >> 1;
         er = e + 1;
      end
      if (er >= 255) return {3'b101, b.sign, 8'hFF, 23'h0};
      if (e <= 0) return {3'b011, b.sign, 31'h0};
      return {2'b00, inx, b.sign, 8'(er), 23'(q)};
   endfunction

   function automatic beat_t gen();
      beat_t b;
      int k, p, x;
      b.sign = 1'($urandom_range(0, 1));
      x      = int'($urandom_range(0, 360)) - 40;
      b.exp  = 10'(x);
      b.nan  = 1'b0;
      b.inf  = 1'b0;
      b.mant = 48'({$urandom(), $urandom()});
      b.lz   = 6'($urandom_range(0, 63));
      k      = int'($urandom_range(0, 99));
      if (k < 4) b.nan = 1'b1;
      else if (k < 8) b.inf = 1'b1;
      else if (k < 12) begin
         b.mant = '0;
         b.lz   = 6'($urandom_range(48, 63));
      end else begin
         p = (k < 40) ? int'($urandom_range(46, 47)) : int'($urandom_range(0, 47));
         b.mant = (b.mant & ((48'd1 << p) - 48'd1)) | (48'd1 << p);
         b.lz   = 6'(47 - p);
      end
      return b;
   endfunction

   task automatic set_inputs(input beat_t b);
      in_sign   = b.sign;
      in_exp    = b.exp;
      in_mant   = b.mant;
      in_lz     = b.lz;
      in_is_nan = b.nan;
      in_is_inf = b.inf;
   endtask

   function automatic vec_t mk(input string name, input logic sign, input int exp,
                               input logic [47:0] mant, input int lz, input logic nan,
                               input logic inf, input logic [31:0] data, input logic [2:0] flags);
      vec_t v;
      v.name   = name;
      v.b.sign = sign;
      v.b.exp  = 10'(exp);
      v.b.mant = mant;
      v.b.lz   = 6'(lz);
      v.b.nan  = nan;
      v.b.inf  = inf;
      v.data   = data;
      v.flags  = flags;
      return v;
   endfunction

   // Scoreboard: queue holds beats accepted but not yet delivered.
   always @(negedge clk) begin
      beat_t b;
      logic [34:0] e;
      if (!rst_n) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else if (sb_en) begin
         check("in_ready_rule", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
         if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(held_d));
            check("stall_flags", 64'(out_flags), 64'(held_f));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got 0x%0h expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               check("stream_data", 64'(out_data), 64'(e[31:0]));
               check("stream_flags", 64'(out_flags), 64'(e[34:32]));
            end
         end
         if (in_valid && in_ready) begin
            b.sign = in_sign; b.exp = in_exp; b.mant = in_mant;
            b.lz = in_lz; b.nan = in_is_nan; b.inf = in_is_inf;
            exp_q.push_back(model(b));
         end
         stall_prev = out_valid && !out_ready;
         held_d     = out_data;
         held_f     = out_flags;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic apply_vec(input vec_t v);
      int lat;
      @(posedge clk); #1;
      set_inputs(v.b);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      check({v.name, "_latency"}, 64'(lat), 64'd2);
      check({v.name, "_data"}, 64'(out_data), 64'(v.data));
      check({v.name, "_flags"}, 64'(out_flags), 64'(v.flags));
   endtask

   // mode 0: out_ready 1,0,0,1 pattern; mode 1: random ready and gaps; mode 2: always ready, no gaps.
   task automatic run_stream(input int n, input int mode, output int cyc);
      int  sent;
      bit  take;
      sent = 0;
      take = 1'b0;
      cyc  = 0;
      in_valid = 1'b0;
      while ((sent < n || exp_q.size() != 0) && cyc < 20 * n + 50) begin
         @(posedge clk); #1;
         cyc++;
         if (take) begin
            in_valid = 1'b0;
            take = 1'b0;
         end
         case (mode)
            0:       out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
            1:       out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b1;
         endcase
         if (!in_valid && sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
            set_inputs(gen());
            in_valid = 1'b1;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            take = 1'b1;
            sent++;
         end
         #1;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      check("stream_sent", 64'(sent), 64'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[$];
      int   cyc;
      beat_t b;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_out_flags", 64'(out_flags), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", 64'(in_ready), 64'd1);

      vecs.push_back(mk("one_x_one",     0, 127, 48'h400000000000, 1,  0, 0, 32'h3F800000, 3'b000));
      vecs.push_back(mk("p15_x_p15",     0, 127, 48'h900000000000, 0,  0, 0, 32'h40100000, 3'b000));
      vecs.push_back(mk("tie_odd_up",    0, 127, 48'h800001800000, 0,  0, 0, 32'h40000002, 3'b001));
      vecs.push_back(mk("tie_even_keep", 0, 127, 48'h800002800000, 0,  0, 0, 32'h40000002, 3'b001));
      vecs.push_back(mk("above_half",    0, 127, 48'h800000C00000, 0,  0, 0, 32'h40000001, 3'b001));
      vecs.push_back(mk("sticky_only",   0, 127, 48'h800000400000, 0,  0, 0, 32'h40000000, 3'b001));
      vecs.push_back(mk("carry_mid",     0, 127, 48'hFFFFFF800000, 0,  0, 0, 32'h40800000, 3'b001));
      vecs.push_back(mk("carry_ovf_255", 0, 254, 48'hFFFFFF800000, 0,  0, 0, 32'h7F800000, 3'b101));
      vecs.push_back(mk("carry_254_ovf", 0, 253, 48'hFFFFFF800000, 0,  0, 0, 32'h7F800000, 3'b101));
      vecs.push_back(mk("max_exp_exact", 0, 253, 48'h800000000000, 0,  0, 0, 32'h7F000000, 3'b000));
      vecs.push_back(mk("underflow_neg", 1, -20, 48'h400000000000, 1,  0, 0, 32'h80000000, 3'b011));
      vecs.push_back(mk("e1_zero_carry", 0, -1,  48'hFFFFFF800000, 0,  0, 0, 32'h00000000, 3'b011));
      vecs.push_back(mk("min_normal",    0, 0,   48'h800000000000, 0,  0, 0, 32'h00800000, 3'b000));
      vecs.push_back(mk("deep_lz",       0, 127, 48'h000000000001, 47, 0, 0, 32'h28800000, 3'b000));
      vecs.push_back(mk("zero_pos",      0, 127, 48'h000000000000, 0,  0, 0, 32'h00000000, 3'b000));
      vecs.push_back(mk("zero_neg_lz48", 1, 127, 48'h000000000000, 48, 0, 0, 32'h80000000, 3'b000));
      vecs.push_back(mk("lz_ge48_zero",  0, 127, 48'h000000000123, 50, 0, 0, 32'h00000000, 3'b000));
      vecs.push_back(mk("nan",           0, 127, 48'h400000000000, 1,  1, 0, 32'h7FC00000, 3'b000));
      vecs.push_back(mk("nan_over_inf",  1, 300, 48'h000000000000, 0,  1, 1, 32'h7FC00000, 3'b000));
      vecs.push_back(mk("inf_neg",       1, 127, 48'h400000000000, 1,  0, 1, 32'hFF800000, 3'b000));
      vecs.push_back(mk("inf_over_zero", 0, -30, 48'h000000000000, 0,  0, 1, 32'h7F800000, 3'b000));
      foreach (vecs[i]) apply_vec(vecs[i]);
      @(negedge clk);
      check("table_drained_valid", 64'(out_valid), 64'd0);

      sb_en = 1'b1;
      run_stream(8, 0, cyc);
      run_stream(16, 2, cyc);
      check("full_throughput_cycles", 64'(cyc), 64'd18);

      // Two beats parked in the pipeline, then a reset pulse with out_ready high.
      @(posedge clk); #1;
      out_ready = 1'b0;
      b = gen(); set_inputs(b); in_valid = 1'b1;
      @(posedge clk); #1;
      b = gen(); set_inputs(b);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_seq_full_valid", 64'(out_valid), 64'd1);
      check("rst_seq_full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_seq_out_valid", 64'(out_valid), 64'd0);
      check("rst_seq_out_data", 64'(out_data), 64'd0);
      check("rst_seq_out_flags", 64'(out_flags), 64'd0);
      check("rst_seq_in_ready", 64'(in_ready), 64'd1);
      repeat (5) @(posedge clk);
      run_stream(1, 0, cyc);

      run_stream(300, 1, cyc);
      sb_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
